// File: rtl/ps2_letter_decoder.sv
// PS/2 set-2 receiver that turns letter key releases into 5-bit codes.
// Frame FSM assembles bytes; byte FSM tracks F0/E0 prefixes.
module ps2_letter_decoder #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [4:0] kstrk,
  output logic       kr,
  output logic [7:0] scan_code,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    F_IDLE,
    F_DATA,
    F_PARITY,
    F_STOP
  } fstate_e;

  typedef enum logic [1:0] {
    B_NORMAL,
    B_BREAK,
    B_EXT,
    B_EXT_BREAK
  } bstate_e;

  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] dat_sync_q;
  logic                   clk_prev_q;
  logic                   clk_s;
  logic                   dat_s;
  logic                   fall;

  fstate_e   fstate_q, fstate_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [7:0] shift_q, shift_d;
  logic       par_ok_q, par_ok_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic       err_q, err_d;
  logic       byte_vld;

  bstate_e    bstate_q, bstate_d;
  logic [4:0] kstrk_q, kstrk_d;
  logic       kr_q, kr_d;
  logic [7:0] scan_q, scan_d;
  logic [5:0] lookup;

  // Set-2 make code -> {hit, letter index}.
  function automatic logic [5:0] letter_of(input logic [7:0] b);
    logic [5:0] r;
    r = 6'd0;
    case (b)
      8'h1C: r = {1'b1, 5'd0};
      8'h32: r = {1'b1, 5'd1};
      8'h21: r = {1'b1, 5'd2};
      8'h23: r = {1'b1, 5'd3};
      8'h24: r = {1'b1, 5'd4};
      8'h2B: r = {1'b1, 5'd5};
      8'h34: r = {1'b1, 5'd6};
      8'h33: r = {1'b1, 5'd7};
      8'h43: r = {1'b1, 5'd8};
      8'h3B: r = {1'b1, 5'd9};
      8'h42: r = {1'b1, 5'd10};
      8'h4B: r = {1'b1, 5'd11};
      8'h3A: r = {1'b1, 5'd12};
      8'h31: r = {1'b1, 5'd13};
      8'h44: r = {1'b1, 5'd14};
      8'h4D: r = {1'b1, 5'd15};
      8'h15: r = {1'b1, 5'd16};
      8'h2D: r = {1'b1, 5'd17};
      8'h1B: r = {1'b1, 5'd18};
      8'h2C: r = {1'b1, 5'd19};
      8'h3C: r = {1'b1, 5'd20};
      8'h2A: r = {1'b1, 5'd21};
      8'h1D: r = {1'b1, 5'd22};
      8'h22: r = {1'b1, 5'd23};
      8'h35: r = {1'b1, 5'd24};
      8'h1A: r = {1'b1, 5'd25};
      default: r = 6'd0;
    endcase
    return r;
  endfunction

  assign clk_s = clk_sync_q[SYNC_STAGES-1];
  assign dat_s = dat_sync_q[SYNC_STAGES-1];
  assign fall  = clk_prev_q & ~clk_s;

  // Synchronise the raw PS/2 lines; idle level is high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_data};
      clk_prev_q <= clk_s;
    end
  end

  // Frame FSM state and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fstate_q <= F_IDLE;
      bitcnt_q <= 3'd0;
      shift_q  <= 8'd0;
      par_ok_q <= 1'b0;
      tmo_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      fstate_q <= fstate_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      par_ok_q <= par_ok_d;
      tmo_q    <= tmo_d;
      err_q    <= err_d;
    end
  end

  // Frame FSM: one step per ps2_clk fall; timeout aborts a stalled frame.
  always_comb begin
    fstate_d = fstate_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    par_ok_d = par_ok_q;
    tmo_d    = tmo_q;
    err_d    = 1'b0;
    byte_vld = 1'b0;
    unique case (fstate_q)
      F_IDLE: begin
        tmo_d = '0;
        if (fall && !dat_s) begin
          fstate_d = F_DATA;
          bitcnt_d = 3'd0;
        end
      end
      F_DATA: begin
        if (fall) begin
          shift_d  = {dat_s, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            fstate_d = F_PARITY;
          end
        end
      end
      F_PARITY: begin
        if (fall) begin
          par_ok_d = ^{shift_q, dat_s};
          fstate_d = F_STOP;
        end
      end
      F_STOP: begin
        if (fall) begin
          fstate_d = F_IDLE;
          if (dat_s && par_ok_q) begin
            byte_vld = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
    endcase
    if (fstate_q != F_IDLE) begin
      if (fall) begin
        tmo_d = '0;
      end else if (tmo_q == TMO_LAST) begin
        tmo_d    = '0;
        fstate_d = F_IDLE;
        err_d    = 1'b1;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  // Byte FSM state and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bstate_q <= B_NORMAL;
      kstrk_q  <= 5'd0;
      kr_q     <= 1'b0;
      scan_q   <= 8'd0;
    end else begin
      bstate_q <= bstate_d;
      kstrk_q  <= kstrk_d;
      kr_q     <= kr_d;
      scan_q   <= scan_d;
    end
  end

  assign lookup = letter_of(shift_q);

  // Byte FSM: emit a letter only for a plain F0-prefixed release.
  always_comb begin
    bstate_d = bstate_q;
    kstrk_d  = kstrk_q;
    kr_d     = 1'b0;
    scan_d   = scan_q;
    if (byte_vld) begin
      scan_d = shift_q;
      unique case (bstate_q)
        B_NORMAL: begin
          if (shift_q == 8'hF0) begin
            bstate_d = B_BREAK;
          end else if (shift_q == 8'hE0) begin
            bstate_d = B_EXT;
          end
        end
        B_BREAK: begin
          bstate_d = B_NORMAL;
          if (lookup[5]) begin
            kstrk_d = lookup[4:0];
            kr_d    = 1'b1;
          end
        end
        B_EXT: begin
          bstate_d = (shift_q == 8'hF0) ? B_EXT_BREAK : B_NORMAL;
        end
        B_EXT_BREAK: begin
          bstate_d = B_NORMAL;
        end
      endcase
    end
  end

  assign kstrk     = kstrk_q;
  assign kr        = kr_q;
  assign scan_code = scan_q;
  assign frame_err = err_q;

endmodule
